// File: rtl/jump_physics.sv
// Frame-ticked jump/slide vertical-motion controller: velocity + gravity arc, timed slide, buffered requests.
// Optional air (double) jump when JUMP_DOUBLE_EN is defined; all outputs registered, updates only on frame_tick.
module jump_physics #(
   parameter int WIDTH        = 12,
   parameter int V0           = 12,
   parameter int GRAVITY      = 1,
   parameter int MAX_FALL     = 16,
   parameter int CEILING      = 200,
   parameter int SLIDE_FRAMES = 30
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_tick,
   input  logic             jump_req,
   input  logic             slide_req,
   output logic [WIDTH-1:0] height,
   output logic [WIDTH-1:0] vel,
   output logic             is_jumping,
   output logic             is_sliding,
   output logic             landed
);

   typedef enum logic [1:0] {IDLE, RISE, FALL, SLIDE} state_t;

   localparam int CW = $clog2(SLIDE_FRAMES + 1);

   localparam logic signed [WIDTH:0]   CEIL_S    = (WIDTH+1)'(CEILING);
   localparam logic signed [WIDTH:0]   NEG_MAX_S = (WIDTH+1)'(-MAX_FALL);
   localparam logic signed [WIDTH:0]   GRAV_S    = (WIDTH+1)'(GRAVITY);
   localparam logic signed [WIDTH:0]   HZERO     = '0;
   localparam logic signed [WIDTH-1:0] VZERO     = '0;
   localparam logic signed [WIDTH-1:0] V0_S      = WIDTH'(V0);
   localparam logic [CW-1:0]           SLIDE_CNT = CW'(SLIDE_FRAMES);
   localparam logic [CW-1:0]           CNT_ONE   = CW'(1);

   state_t                  state_q, state_d;
   logic [WIDTH-1:0]        height_q, height_d;
   logic signed [WIDTH-1:0] vel_q, vel_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    jump_pend_q, jump_pend_d;
   logic                    slide_pend_q, slide_pend_d;
   logic                    landed_q, landed_d;
`ifdef JUMP_DOUBLE_EN
   logic                    air_q, air_d;
`endif

   logic                    jump_now, slide_now;
   logic signed [WIDTH:0]   h_next, v_grav;

   // A request arriving in the tick cycle itself still counts for that tick.
   assign jump_now  = jump_pend_q | jump_req;
   assign slide_now = slide_pend_q | slide_req;

   assign h_next = $signed({1'b0, height_q}) + $signed({vel_q[WIDTH-1], vel_q});
   assign v_grav = $signed({vel_q[WIDTH-1], vel_q}) - GRAV_S;

   always_comb begin
      state_d      = state_q;
      height_d     = height_q;
      vel_d        = vel_q;
      cnt_d        = cnt_q;
      landed_d     = 1'b0;
      jump_pend_d  = frame_tick ? 1'b0 : jump_now;
      slide_pend_d = frame_tick ? 1'b0 : slide_now;
`ifdef JUMP_DOUBLE_EN
      air_d        = air_q;
`endif
      if (frame_tick) begin
         case (state_q)
            IDLE: begin
               if (jump_now) begin
                  vel_d   = V0_S;
                  state_d = RISE;
               end else if (slide_now) begin
                  cnt_d   = SLIDE_CNT;
                  state_d = SLIDE;
               end
            end
            RISE, FALL: begin
               if (h_next <= HZERO) begin
                  height_d = '0;
                  vel_d    = VZERO;
                  state_d  = IDLE;
                  landed_d = 1'b1;
`ifdef JUMP_DOUBLE_EN
                  air_d    = 1'b1;
`endif
               end else begin
                  // Clamp only upward motion, so a body resting at the ceiling with vel=0 starts to descend.
                  if (h_next >= CEIL_S && vel_q > VZERO) begin
                     height_d = CEIL_S[WIDTH-1:0];
                     vel_d    = VZERO;
                     state_d  = FALL;
                  end else begin
                     height_d = h_next[WIDTH-1:0];
                     vel_d    = (v_grav < NEG_MAX_S) ? NEG_MAX_S[WIDTH-1:0] : v_grav[WIDTH-1:0];
                     state_d  = (vel_d > VZERO) ? RISE : FALL;
                  end
                  if (slide_now) begin
                     vel_d   = NEG_MAX_S[WIDTH-1:0];
                     state_d = FALL;
                  end
`ifdef JUMP_DOUBLE_EN
                  if (jump_now && air_q) begin
                     vel_d   = V0_S;
                     state_d = RISE;
                     air_d   = 1'b0;
                  end
`endif
               end
            end
            SLIDE: begin
               if (jump_now) begin
                  vel_d   = V0_S;
                  state_d = RISE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
                  if (cnt_q <= CNT_ONE) begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         height_q     <= '0;
         vel_q        <= '0;
         cnt_q        <= '0;
         jump_pend_q  <= 1'b0;
         slide_pend_q <= 1'b0;
         landed_q     <= 1'b0;
`ifdef JUMP_DOUBLE_EN
         air_q        <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         height_q     <= height_d;
         vel_q        <= vel_d;
         cnt_q        <= cnt_d;
         jump_pend_q  <= jump_pend_d;
         slide_pend_q <= slide_pend_d;
         landed_q     <= landed_d;
`ifdef JUMP_DOUBLE_EN
         air_q        <= air_d;
`endif
      end
   end

   assign height     = height_q;
   assign vel        = vel_q;
   assign is_jumping = (state_q == RISE) || (state_q == FALL);
   assign is_sliding = (state_q == SLIDE);
   assign landed     = landed_q;

endmodule

// File: tb/tb_jump_physics.sv
// Directed bench for jump_physics: default instance plus a CEILING=50 instance sharing all inputs.
module tb_jump_physics;

   logic        clk;
   logic        rst_n;
   logic        frame_tick;
   logic        jump_req;
   logic        slide_req;
   logic [11:0] height, vel, c_height, c_vel;
   logic        is_jumping, is_sliding, landed;
   logic        c_jumping, c_sliding, c_landed;

   int checks   = 0;
   int failures = 0;

   int exp_h [0:25] = '{0, 12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78,
                        78, 77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};
   int exp_c [0:16] = '{0, 12, 23, 33, 42, 50, 50, 49, 47, 44, 40, 35, 29, 22, 14, 5, 0};
   int exp_ff [0:4] = '{62, 46, 30, 14, 0};

   jump_physics dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .jump_req(jump_req),
      .slide_req(slide_req), .height(height), .vel(vel), .is_jumping(is_jumping),
      .is_sliding(is_sliding), .landed(landed)
   );

   jump_physics #(.CEILING(50)) dut_c (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .jump_req(jump_req),
      .slide_req(slide_req), .height(c_height), .vel(c_vel), .is_jumping(c_jumping),
      .is_sliding(c_sliding), .landed(c_landed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic j = 1'b0, input logic s = 1'b0);
      @(negedge clk);
      frame_tick = 1'b1;
      jump_req   = j;
      slide_req  = s;
      @(negedge clk);
      frame_tick = 1'b0;
      jump_req   = 1'b0;
      slide_req  = 1'b0;
   endtask

   task automatic pulse_jump();
      @(negedge clk);
      jump_req = 1'b1;
      @(negedge clk);
      jump_req = 1'b0;
   endtask

   task automatic fall_to_ground(input string tag);
      int n = 0;
      while (is_jumping && n < 80) begin
         tick();
         n++;
      end
      chk({tag, "_landed"}, landed, 1);
      chk({tag, "_h0"}, height, 0);
      @(negedge clk);
      chk({tag, "_landed_off"}, landed, 0);
   endtask

   initial begin
      rst_n = 1'b0; frame_tick = 1'b0; jump_req = 1'b0; slide_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_height", height, 0);
      chk("rst_vel", vel, 0);
      chk("rst_jumping", is_jumping, 0);
      chk("rst_sliding", is_sliding, 0);
      chk("rst_landed", landed, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic arc on both instances
      pulse_jump();
      repeat (2) @(negedge clk);
      tick();
      chk("launch_h", height, 0);
      chk("launch_v", $signed(vel), 12);
      chk("launch_jumping", is_jumping, 1);
      for (int i = 1; i <= 25; i++) begin
         tick();
         chk($sformatf("arc_h_t%0d", i), height, exp_h[i]);
         chk($sformatf("ceil_h_t%0d", i), c_height, (i <= 16) ? exp_c[i] : 0);
         if (i == 5) chk("ceil_v_clamp", $signed(c_vel), 0);
         if (i == 6) chk("ceil_v_descend", $signed(c_vel), -1);
         if (i == 16) chk("ceil_landed", c_landed, 1);
         if (i == 12) begin
            chk("apex_v", $signed(vel), 0);
            chk("apex_jumping", is_jumping, 1);
         end
      end
      chk("arc_landed", landed, 1);
      chk("arc_idle", is_jumping, 0);
      chk("arc_v0", $signed(vel), 0);
      @(negedge clk);
      chk("arc_landed_1cyc", landed, 0);

      // Buffered jump with slide on the tick: jump wins, both flags cleared
      pulse_jump();
      repeat (4) @(negedge clk);
      tick(1'b0, 1'b1);
      chk("buf_launch_v", $signed(vel), 12);
      chk("buf_jumping", is_jumping, 1);
      chk("buf_no_slide", is_sliding, 0);
      tick();
      chk("buf_h1", height, 12);
      chk("buf_v1", $signed(vel), 11);
      fall_to_ground("buf");
      tick();
      chk("buf_cleared_j", is_jumping, 0);
      chk("buf_cleared_s", is_sliding, 0);

      // Slide: 30 ticks, restart ignored
      @(negedge clk); slide_req = 1'b1;
      @(negedge clk); slide_req = 1'b0;
      tick();
      chk("slide_start", is_sliding, 1);
      chk("slide_not_jump", is_jumping, 0);
      for (int i = 1; i <= 29; i++) begin
         tick(1'b0, (i == 15));
      end
      chk("slide_t29", is_sliding, 1);
      tick();
      chk("slide_t30_end", is_sliding, 0);
      tick();
      chk("slide_no_restart", is_sliding, 0);

      // Jump cancels slide at slide tick 10
      tick(1'b0, 1'b1);
      chk("slide2_start", is_sliding, 1);
      repeat (9) tick();
      tick(1'b1, 1'b0);
      chk("slidejump_sliding", is_sliding, 0);
      chk("slidejump_jumping", is_jumping, 1);
      chk("slidejump_v", $signed(vel), 12);
      chk("slidejump_h", height, 0);
      fall_to_ground("slidejump");

      // Fast-fall from apex
      pulse_jump();
      tick();
      repeat (12) tick();
      chk("ff_apex_h", height, 78);
      tick(1'b0, 1'b1);
      chk("ff_h", height, 78);
      chk("ff_v", $signed(vel), -16);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("ff_h%0d", i), height, exp_ff[i]);
      end
      chk("ff_landed", landed, 1);
      @(negedge clk);

      // Air jump at apex
      pulse_jump();
      tick();
      repeat (12) tick();
      chk("dj_apex_h", height, 78);
      tick(1'b1, 1'b0);
      chk("dj_h", height, 78);
`ifdef JUMP_DOUBLE_EN
      chk("dj_v", $signed(vel), 12);
      repeat (12) tick();
      chk("dj_top_h", height, 156);
      chk("dj_top_v", $signed(vel), 0);
      tick(1'b1, 1'b0);
      chk("dj_third_h", height, 156);
      chk("dj_third_v", $signed(vel), -1);
      fall_to_ground("dj");
      tick(1'b1, 1'b0);
      repeat (12) tick();
      tick(1'b1, 1'b0);
      chk("dj_restored_v", $signed(vel), 12);
      fall_to_ground("dj2");
`else
      chk("nodj_v", $signed(vel), -1);
      chk("nodj_state", is_jumping, 1);
      fall_to_ground("nodj");
`endif

      // Reset mid-air at h=33
      pulse_jump();
      tick();
      repeat (3) tick();
      chk("rstair_h_before", height, 33);
      #2 rst_n = 1'b0;
      #1;
      chk("rstair_h", height, 0);
      chk("rstair_v", vel, 0);
      chk("rstair_jumping", is_jumping, 0);
      chk("rstair_landed", landed, 0);
      chk("rstair_c_h", c_height, 0);
      repeat (2) @(negedge clk);
      chk("rstair_landed_later", landed, 0);
      rst_n = 1'b1;
      tick();
      chk("rstair_idle_after", is_jumping, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
